fp_normalize_round: RTL

FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

---
 rtl/fp_normalize_round.sv | 117 +++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// Normalize-and-round stage: turns a signed-magnitude fixed-point accumulator
// into IEEE-754 binary32 through a two-stage valid/ready pipeline.
module fp_normalize_round #(
    parameter int FRAC = 62
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [63:0] in_mag,
    input  logic [9:0]  in_exp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_unf
);

    logic        s1_valid;
    logic        s1_sign;
    logic        s1_zero;
    logic [62:0] s1_norm;
    logic [11:0] s1_exp;

    logic        s2_valid;
    logic        s2_ready;

    logic [5:0]  msb;
    logic [5:0]  shamt;
    logic [62:0] norm_in;
    logic [11:0] exp_in;

    logic        guard;
    logic        sticky;
    logic        rnd_inc;
    logic [23:0] mant_sum;
    logic [11:0] exp_rnd;
    logic [31:0] pack_data;
    logic        pack_ovf;
    logic        pack_unf;

    // Handshake: a stage may load when it is empty or its content leaves.
    assign s2_ready  = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_ready;
    assign out_valid = s2_valid;

    // Stage 1: leading-one detect and normalize.
    always_comb begin
        msb = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (in_mag[i]) msb = 6'(i);
        end
    end

    // The leading one lands on bit 63 and is implicit, so only bits below it are kept.
    assign shamt   = 6'd63 - msb;
    assign norm_in = in_mag[62:0] << shamt;
    assign exp_in  = {{2{in_exp[9]}}, in_exp} + {6'd0, msb} - 12'(FRAC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_sign <= in_sign;
            s1_zero <= (in_mag == '0);
            s1_norm <= norm_in;
            s1_exp  <= exp_in;
        end
    end

    // Stage 2: round to nearest even, then range check and pack.
    always_comb begin
        guard     = s1_norm[39];
        sticky    = |s1_norm[38:0];
        rnd_inc   = guard & (sticky | s1_norm[40]);
        mant_sum  = {1'b0, s1_norm[62:40]} + 24'(rnd_inc);
        exp_rnd   = s1_exp + {11'd0, mant_sum[23]};
        pack_data = '0;
        pack_ovf  = 1'b0;
        pack_unf  = 1'b0;
        if (s1_zero) begin
            pack_data = '0;
        end else if ($signed(exp_rnd) >= 12'sd255) begin
            pack_data = {s1_sign, 8'hFF, 23'h0};
            pack_ovf  = 1'b1;
        end else if ($signed(exp_rnd) <= 12'sd0) begin
            pack_data = {s1_sign, 31'h0};
            pack_unf  = 1'b1;
        end else begin
            pack_data = {s1_sign, exp_rnd[7:0], mant_sum[22:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
            out_unf  <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= pack_data;
                out_ovf  <= pack_ovf;
                out_unf  <= pack_unf;
            end
        end
    end

endmodule
